// File: rtl/int2float_unit.sv
// Converts a signed 32-bit integer to an IEEE-754 single-precision word.
// Normalization shifts one bit per clock; rounding takes one extra cycle.
module int2float_unit #(
   parameter int ROUND_EN = 1,
   parameter int EXP_BIAS = 127
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_inexact
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   localparam logic [7:0] EXP_TOP = 8'(EXP_BIAS + 31);

   state_t      state_reg, state_next;
   logic        sign_reg, sign_next;
   logic [31:0] mag_reg, mag_next;
   logic [7:0]  exp_reg, exp_next;
   logic [31:0] out_data_reg, out_data_next;
   logic        inexact_reg, inexact_next;

   logic [31:0] abs_in;
   logic [22:0] frac;
   logic        guard;
   logic        sticky;
   logic        round_up;
   logic [23:0] frac_sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         sign_reg     <= 1'b0;
         mag_reg      <= 32'd0;
         exp_reg      <= 8'd0;
         out_data_reg <= 32'd0;
         inexact_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sign_reg     <= sign_next;
         mag_reg      <= mag_next;
         exp_reg      <= exp_next;
         out_data_reg <= out_data_next;
         inexact_reg  <= inexact_next;
      end
   end

   always_comb begin
      // -2^31 wraps to 0x80000000, which is exactly its magnitude as unsigned.
      abs_in   = in_data[31] ? (~in_data + 32'd1) : in_data;
      frac     = mag_reg[30:8];
      guard    = mag_reg[7];
      sticky   = |mag_reg[6:0];
      round_up = (ROUND_EN != 0) && guard && (sticky || frac[0]);
      frac_sum = {1'b0, frac} + {23'd0, round_up};

      state_next    = state_reg;
      sign_next     = sign_reg;
      mag_next      = mag_reg;
      exp_next      = exp_reg;
      out_data_next = out_data_reg;
      inexact_next  = inexact_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               sign_next = in_data[31];
               mag_next  = abs_in;
               exp_next  = EXP_TOP;
               if (abs_in == 32'd0) begin
                  out_data_next = 32'd0;
                  inexact_next  = 1'b0;
                  state_next    = DONE;
               end else begin
                  state_next = NORM;
               end
            end
         end
         NORM: begin
            if (mag_reg[31]) begin
               state_next = ROUND;
            end else begin
               mag_next = mag_reg << 1;
               exp_next = exp_reg - 8'd1;
            end
         end
         ROUND: begin
            // A mantissa carry leaves frac_sum[22:0] at zero and bumps the exponent.
            out_data_next = {sign_reg, exp_reg + {7'd0, frac_sum[23]}, frac_sum[22:0]};
            inexact_next  = guard | sticky;
            state_next    = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready    = (state_reg == IDLE) && !reset;
   assign out_valid   = (state_reg == DONE);
   assign out_data    = out_data_reg;
   assign out_inexact = inexact_reg;

endmodule
